ascon_host_driver: RTL
======================

ASCON_HOST_DRIVER -- requirements
Module: ascon_host_driver

Interface
REQ-001 SHALL have the port clk, input, width 1: the single clock; all state changes on the rising edge.
REQ-002 SHALL have the port rstn, input, width 1: asynchronous, active-low reset.
REQ-003 SHALL have the ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_encrypt (in, 1), cmd_ad_n (in, 4), cmd_txt_n (in, 4) and cmd_tag (in, 128): operation command; cmd_ad_n is AD blocks minus 1, cmd_txt_n is text blocks minus 1, cmd_tag is the expected tag for decrypt.
REQ-004 SHALL have the ports in_valid (in, 1), in_ready (out, 1) and in_data (in, 128): input block stream; AD blocks first, then text blocks.
REQ-005 SHALL have the ports out_valid (out, 1), out_ready (in, 1), out_data (out, 128) and out_is_tag (out, 1): output block stream.
REQ-006 SHALL have the ports done (out, 1) and tag_ok (out, 1): one-cycle completion pulse, and the authentication result valid while done=1.
REQ-007 SHALL have the core-side outputs core_start, core_din (128), core_dinReq, core_encrypt, core_last_block, core_sel_data and core_doAck.
REQ-008 SHALL have the core-side inputs core_busy, core_finished, core_dinAck, core_dout (128) and core_doReq.

Function
REQ-009 SHALL use a state machine with states IDLE, START, FEED_AD, FEED_TXT, WAIT_TAG, WAIT_FIN.
REQ-010 In IDLE, cmd_ready SHALL be 1; a cmd_valid&cmd_ready edge SHALL latch all cmd fields, load ad_cnt=cmd_ad_n and txt_cnt=cmd_txt_n, and go to START.
REQ-011 START SHALL drive core_start=1 for exactly one cycle, then go to FEED_AD.
REQ-012 core_encrypt SHALL equal the latched cmd_encrypt from START until return to IDLE.
REQ-013 in_ready SHALL be 1 only in FEED_AD/FEED_TXT while core_dinReq=0 and no staged block is held; an in_valid&in_ready edge SHALL stage in_data into core_din and set core_dinReq=1 on the next cycle.
REQ-014 core_din, core_sel_data (0 in FEED_AD, 1 in FEED_TXT) and core_last_block (1 when the active counter is 0) SHALL be stable while core_dinReq=1.
REQ-015 When core_dinAck=1 is sampled, core_dinReq SHALL fall on that edge; if the active counter is 0, FEED_AD SHALL go to FEED_TXT and FEED_TXT SHALL go to WAIT_TAG; otherwise the counter SHALL decrement.
REQ-016 core_doAck SHALL be combinational: core_doReq & ~obuf_full.
REQ-017 On a core_doReq&core_doAck edge, the block SHALL capture core_dout into a 1-entry output buffer (out_valid=1); out_is_tag=1 only for the capture made in WAIT_TAG.
REQ-018 The output buffer SHALL clear on out_valid&out_ready; a simultaneous capture and drain SHALL be impossible, because core_doAck is low while the buffer is full.
REQ-019 The tag capture in WAIT_TAG SHALL register tag_ok = ~encrypt & (core_dout == cmd_tag); tag_ok SHALL be 0 for encrypt.
REQ-020 WAIT_TAG SHALL go to WAIT_FIN after the tag capture; WAIT_FIN SHALL go to IDLE when core_finished=1 and out_valid=0, pulsing done=1 for one cycle.
REQ-021 Text outputs SHALL number exactly cmd_txt_n+1, followed by exactly one tag output.
REQ-022 cmd_valid in any state other than IDLE SHALL be ignored (cmd_ready=0).
REQ-023 in_valid outside FEED states SHALL be ignored; excess input blocks SHALL not be consumed.

Reset
REQ-024 rstn=0 SHALL immediately force IDLE, cmd_ready=1 (after reset), in_ready=0, out_valid=0, out_is_tag=0, done=0, tag_ok=0, core_start=0, core_dinReq=0, core_sel_data=0, core_last_block=0, core_encrypt=0, and clear core_din, out_data, both counters and the latched cmd fields.
REQ-025 Reset mid-operation SHALL discard staged and buffered blocks with no further output, and the block SHALL accept a new command after release.

Verification
REQ-026 Encrypt, ad_n=0, txt_n=0, key/nonce all-zero, AD=0, PT=0 -> core_start pulse once, 2 dinAck, out: 1 text, then tag with out_is_tag=1, done pulse, tag_ok=0.
REQ-027 Round trip: encrypt with ad_n=1, txt_n=2, then decrypt the ciphertext with cmd_tag = the emitted tag -> decrypt outputs equal the original PT blocks, done with tag_ok=1; repeat with tag bit 0 flipped -> tag_ok=0.
REQ-028 out_ready held 0 for 50 cycles during a text block -> core_doAck=0, core_doReq held, no block lost or duplicated after release, output count = txt_n+2.
REQ-029 in_valid gaps of 0-20 random cycles and ad_n=15, txt_n=15 -> exactly 16 sel_data=0 and 16 sel_data=1 handshakes, last_block=1 only on the 16th of each group.
REQ-030 rstn pulsed low during FEED_TXT -> all outputs at reset values in the same cycle; a subsequent clean command completes normally.
REQ-031 cmd_valid=1 continuously -> exactly one command accepted per IDLE visit, none accepted while busy.

Source files
------------

// File: rtl/ascon_host_driver_if.sv
// rtl/ascon_host_driver_if.sv - host-side command, input block and output block streams of the Ascon driver
interface ascon_host_driver_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_encrypt;
  logic [3:0]   cmd_ad_n;
  logic [3:0]   cmd_txt_n;
  logic [127:0] cmd_tag;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_is_tag;
  logic         done;
  logic         tag_ok;

  modport master (
    output cmd_valid, cmd_encrypt, cmd_ad_n, cmd_txt_n, cmd_tag,
    input  cmd_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_is_tag,
    output out_ready,
    input  done, tag_ok
  );

  modport slave (
    input  cmd_valid, cmd_encrypt, cmd_ad_n, cmd_txt_n, cmd_tag,
    output cmd_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_is_tag,
    input  out_ready,
    output done, tag_ok
  );
endinterface

// File: rtl/ascon_host_driver.sv
// rtl/ascon_host_driver.sv - sequences one AEAD command and its AD/text block streams into an Ascon core
module ascon_host_driver (
  input  logic               clk,
  input  logic               rstn,
  ascon_host_driver_if.slave host,
  output logic               core_start,
  output logic [127:0]       core_din,
  output logic               core_dinReq,
  output logic               core_encrypt,
  output logic               core_last_block,
  output logic               core_sel_data,
  output logic               core_doAck,
  input  logic               core_busy,
  input  logic               core_finished,
  input  logic               core_dinAck,
  input  logic [127:0]       core_dout,
  input  logic               core_doReq
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED_AD,
    FEED_TXT,
    WAIT_TAG,
    WAIT_FIN
  } state_t;

  state_t       state;
  logic         enc_q;
  logic [127:0] tag_q;
  logic [3:0]   ad_cnt;
  logic [3:0]   txt_cnt;

  logic         out_valid_q;
  logic [127:0] out_data_q;
  logic         out_is_tag_q;
  logic         done_q;
  logic         tag_ok_q;

  logic         feeding;
  logic         in_fire;
  logic         din_fire;
  logic         do_fire;
  logic         out_fire;
  logic         act_zero;
  logic         unused_busy;

  assign unused_busy = core_busy;

  assign feeding   = (state == FEED_AD) || (state == FEED_TXT);
  assign in_fire   = host.in_valid && host.in_ready;
  assign din_fire  = core_dinReq && core_dinAck;
  assign do_fire   = core_doReq && core_doAck;
  assign out_fire  = out_valid_q && host.out_ready;
  assign act_zero  = (state == FEED_TXT) ? (txt_cnt == 4'd0) : (ad_cnt == 4'd0);

  assign host.cmd_ready  = (state == IDLE);
  assign host.in_ready   = feeding && !core_dinReq;
  assign host.out_valid  = out_valid_q;
  assign host.out_data   = out_data_q;
  assign host.out_is_tag = out_is_tag_q;
  assign host.done       = done_q;
  assign host.tag_ok     = tag_ok_q;

  // The single-entry output buffer back-pressures the core directly.
  assign core_doAck   = core_doReq && !out_valid_q;
  assign core_encrypt = enc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      enc_q           <= 1'b0;
      tag_q           <= '0;
      ad_cnt          <= '0;
      txt_cnt         <= '0;
      core_start      <= 1'b0;
      core_din        <= '0;
      core_dinReq     <= 1'b0;
      core_sel_data   <= 1'b0;
      core_last_block <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_is_tag_q    <= 1'b0;
      done_q          <= 1'b0;
      tag_ok_q        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done_q     <= 1'b0;

      if (do_fire) begin
        out_data_q   <= core_dout;
        out_valid_q  <= 1'b1;
        out_is_tag_q <= (state == WAIT_TAG);
        if (state == WAIT_TAG) begin
          tag_ok_q <= !enc_q && (core_dout == tag_q);
        end
      end else if (out_fire) begin
        out_valid_q  <= 1'b0;
        out_is_tag_q <= 1'b0;
      end

      // Staged block and its qualifiers stay frozen until the core acknowledges.
      if (in_fire) begin
        core_din        <= host.in_data;
        core_dinReq     <= 1'b1;
        core_sel_data   <= (state == FEED_TXT);
        core_last_block <= act_zero;
      end else if (din_fire) begin
        core_dinReq <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (host.cmd_valid) begin
            enc_q      <= host.cmd_encrypt;
            tag_q      <= host.cmd_tag;
            ad_cnt     <= host.cmd_ad_n;
            txt_cnt    <= host.cmd_txt_n;
            tag_ok_q   <= 1'b0;
            core_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          state <= FEED_AD;
        end
        FEED_AD: begin
          if (din_fire) begin
            if (ad_cnt == 4'd0) begin
              state <= FEED_TXT;
            end else begin
              ad_cnt <= ad_cnt - 4'd1;
            end
          end
        end
        FEED_TXT: begin
          if (din_fire) begin
            if (txt_cnt == 4'd0) begin
              state <= WAIT_TAG;
            end else begin
              txt_cnt <= txt_cnt - 4'd1;
            end
          end
        end
        WAIT_TAG: begin
          if (do_fire) begin
            state <= WAIT_FIN;
          end
        end
        WAIT_FIN: begin
          // Hold completion until the tag has left the buffer.
          if (core_finished && !out_valid_q) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
